// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines, frames
// 11-bit packets, decodes set-2 E0/F0 prefixes into make/break events and
// queues them in a first-word-fall-through FIFO.
// Optional build macro PS2_KEYSTATE_EN adds the keystate/pressed_count ports
// and the held-key tracking behind them.
module ps2_keyboard_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic         ev_valid,
  input  logic         ev_ready,
  output logic [7:0]   ev_code,
  output logic         ev_ext,
  output logic         ev_break,
  output logic         frame_err,
  output logic         overflow
`ifdef PS2_KEYSTATE_EN
  ,
  output logic [511:0] keystate,
  output logic [9:0]   pressed_count
`endif
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic                   filt_clk, fall, fall_bit;
  logic [FCW-1:0]         filt_cnt;
  rx_state_t              state;
  logic [7:0]             shreg, rx_byte;
  logic [2:0]             bit_cnt;
  logic                   par_bit, byte_valid;
  logic [TCW-1:0]         tmo_cnt;
  logic                   ext_flag, brk_flag, is_drop, push, pop, accept;
  logic [9:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Metastability synchronisers on both raw lines, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Glitch filter on the clock; a filtered falling edge captures one data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      fall_bit <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
        fall     <= ~clk_s;
        fall_bit <= data_s;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame receiver with inactivity timeout; emits a byte strobe or frame_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state != S_IDLE && !fall && tmo_cnt == TMO_LAST) begin
        state     <= S_IDLE;
        tmo_cnt   <= '0;
        frame_err <= 1'b1;
      end else begin
        if (fall)                  tmo_cnt <= '0;
        else if (state != S_IDLE)  tmo_cnt <= tmo_cnt + 1'b1;
        case (state)
          S_IDLE: if (fall && !fall_bit) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
          S_DATA: if (fall) begin
            shreg   <= {fall_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: if (fall) begin
            par_bit <= fall_bit;
            state   <= S_STOP;
          end
          S_STOP: if (fall) begin
            state <= S_IDLE;
            if (fall_bit && (^{shreg, par_bit})) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Classify the received byte: prefixes, dropped control codes, key events.
  always_comb begin
    is_drop = 1'b0;
    case (rx_byte)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_drop = 1'b1;
      default:                                  is_drop = 1'b0;
    endcase
    push   = byte_valid && !is_drop && rx_byte != 8'hE0 && rx_byte != 8'hF0;
    pop    = ev_valid && ev_ready;
    accept = push && (count != FIFO_FULL || pop);
  end

  // Prefix flags persist across bytes until a key byte, control byte or error.
  always_ff @(posedge clk) begin
    if (rst || frame_err) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  // Event FIFO; a full FIFO still accepts a push when the head pops that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {ext_flag, brk_flag, rx_byte};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

  assign ev_valid = (count != '0);
  assign ev_code  = mem[rd_ptr][7:0];
  assign ev_break = mem[rd_ptr][8];
  assign ev_ext   = mem[rd_ptr][9];

`ifdef PS2_KEYSTATE_EN
  logic [8:0] key_idx;
  assign key_idx = {ext_flag, rx_byte};

  // Held-key bitmap and population count, updated even when the event drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      keystate      <= '0;
      pressed_count <= '0;
    end else if (push) begin
      if (!brk_flag && !keystate[key_idx]) begin
        keystate[key_idx] <= 1'b1;
        pressed_count     <= pressed_count + 1'b1;
      end else if (brk_flag && keystate[key_idx]) begin
        keystate[key_idx] <= 1'b0;
        pressed_count     <= pressed_count - 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data (minimum 2).
REQ-002 Parameter FILTER_LEN, 8, consecutive equal synced samples needed to change filtered ps2_clk.
REQ-003 Parameter TIMEOUT_CYCLES, 50000, clk cycles without a filtered falling edge before an in-progress frame aborts.
REQ-004 Parameter FIFO_DEPTH, 8, event FIFO entries (power of two, minimum 2).
REQ-005 clk  in  1  system clock; one clock domain; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ps2_clk  in  1  raw PS/2 clock line, asynchronous.
REQ-008 ps2_data  in  1  raw PS/2 data line, asynchronous.
REQ-009 ev_valid  out  1  FIFO head holds an event.
REQ-010 ev_ready  in  1  consumer accepts head event.
REQ-011 ev_code  out  8  scan code (set 2) of head event.
REQ-012 ev_ext  out  1  head event had E0 prefix.
REQ-013 ev_break  out  1  head event is a release (F0 prefix).
REQ-014 frame_err  out  1  one-cycle pulse per rejected or aborted frame.
REQ-015 overflow  out  1  sticky; an event was dropped because the FIFO was full.
REQ-016 keystate  out  512  key held bits, index {ext,code} (PS2_KEYSTATE_EN only).
REQ-017 pressed_count  out  10  number of set keystate bits (PS2_KEYSTATE_EN only).

Function
REQ-018 Both lines SHALL pass through SYNC_STAGES synchronisers; filtered clock SHALL take the synced value only after FILTER_LEN identical consecutive samples.
REQ-019 A filtered 1->0 transition SHALL sample synced ps2_data as one frame bit.
REQ-020 Receiver states: IDLE, DATA (8 bits, LSB first), PARITY, STOP; IDLE->DATA only on a sampled 0 start bit; a sampled 1 in IDLE is ignored.
REQ-021 Parity SHALL be odd over the 8 data bits plus parity bit; stop bit SHALL be 1; any failure SHALL pulse frame_err, discard the byte, clear prefix flags, return to IDLE.
REQ-022 In any non-IDLE state, TIMEOUT_CYCLES cycles since the last falling edge SHALL return to IDLE with a frame_err pulse and clear prefix flags.
REQ-023 Decoder: byte E0 sets ext flag; F0 sets brk flag; AA, FA, EE, FE, 00, FF clear both flags and produce no event; any other byte produces event {code,ext,brk} and clears both flags.
REQ-024 Event SHALL be pushed the cycle after the valid stop bit is sampled; ev_valid SHALL rise the following cycle (no same-cycle bypass).
REQ-025 FIFO is first-word-fall-through; pop occurs when ev_valid and ev_ready; ev_code/ev_ext/ev_break SHALL hold stable while ev_valid and not ev_ready.
REQ-026 Push while full and no pop SHALL drop the new event and set overflow; push and pop in the same cycle when full SHALL accept both.
REQ-027 ev_valid SHALL deassert the cycle after the last entry is popped; pop while empty has no effect.
REQ-028 keystate SHALL update in the push cycle regardless of FIFO fullness: make sets bit, break clears bit.
REQ-029 pressed_count SHALL increment only on a 0->1 bit change and decrement only on 1->0; repeated make (typematic) or break of an unheld key leaves it unchanged but still pushes the event.

Reset
REQ-030 rst SHALL force: receiver IDLE, flags clear, timeout counter 0, FIFO empty, ev_valid 0, ev_code 0, ev_ext 0, ev_break 0, frame_err 0, overflow 0, keystate 0, pressed_count 0; filtered clock and synchronisers reset to 1.
REQ-031 rst asserted mid-frame SHALL discard the partial frame without a frame_err pulse.

Configuration
REQ-032 Macro PS2_KEYSTATE_EN: defined -> keystate and pressed_count ports and tracking present; undefined -> both ports and their logic absent; event stream, frame_err and overflow behaviour identical in both builds.

Verification
REQ-033 Frame 1C, odd parity, stop 1 -> one event code=1C ext=0 break=0, ev_valid two cycles after stop sample, keystate[0x01C]=1, pressed_count=1.
REQ-034 Bytes E0,F0,75 after E0,75 -> events {75,1,0} then {75,1,1}; keystate[0x175] 1 then 0; pressed_count 1 then 0.
REQ-035 Frame 1C with wrong parity -> frame_err pulse, no event; next E0 then 1C frames -> event ext=1.
REQ-036 Start bit plus 4 bits then TIMEOUT_CYCLES idle -> frame_err pulse, IDLE; next full frame 29 decodes correctly.
REQ-037 ev_ready=0, FIFO_DEPTH+1 makes -> first FIFO_DEPTH held in order, overflow=1, last dropped; head stable until ev_ready=1.
REQ-038 Frame AA -> no event, no frame_err; F0 then AA then 1C -> event break=0.
